// File: rtl/rh_bf_uart_loader.sv
// UART program loader for TinyBF: assembles RX bytes into program words and writes them sequentially.
// Optional even-parity frames (8E1) when RH_BF_LOADER_PARITY_EN is defined; otherwise 8N1.
module rh_bf_uart_loader #(
    parameter int BIT_CYCLES = 208,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_en,
    input  logic              uart_rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow,
    output logic              frame_err
);

    localparam int NBYTES = DATA_W / 8;
    localparam int HALF   = BIT_CYCLES / 2;
    localparam int CNT_W  = $clog2(BIT_CYCLES);
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef RH_BF_LOADER_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             state, state_next;
    logic               rx_meta, rx_sync, rx_last;
    logic               prog_q;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
    logic [IDX_W-1:0]   byte_idx;
    logic [DATA_W-1:0]  word_buf, word_next;
    logic               bit_done, rx_fall, prog_rise;
    logic               byte_ok, byte_bad, par_ok;

`ifdef RH_BF_LOADER_PARITY_EN
    logic par_err;
    assign par_ok = ~par_err;
`else
    assign par_ok = 1'b1;
`endif

    assign rx_fall   = rx_last & ~rx_sync;
    assign prog_rise = prog_en & ~prog_q;
    assign bit_done  = (state == S_START) ? (cnt == CNT_W'(HALF - 1))
                                          : (cnt == CNT_W'(BIT_CYCLES - 1));
    assign busy      = (state != S_IDLE) | mem_we;

    // Flops reset to 1 so a held-idle line never looks like a start edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_last <= 1'b1;
            prog_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples its pre-edge input; blocking here would collapse the chain.
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_last <= rx_sync;
            prog_q  <= prog_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        byte_ok    = 1'b0;
        byte_bad   = 1'b0;
        case (state)
            S_IDLE:  if (prog_en && rx_fall) state_next = S_START;
            S_START: if (bit_done) state_next = rx_sync ? S_IDLE : S_DATA;
            S_DATA: begin
                if (bit_done && bit_idx == 3'd7) begin
`ifdef RH_BF_LOADER_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef RH_BF_LOADER_PARITY_EN
            S_PARITY: if (bit_done) state_next = S_STOP;
`endif
            S_STOP: begin
                if (bit_done) begin
                    state_next = S_IDLE;
                    byte_ok    = rx_sync & par_ok;
                    byte_bad   = ~(rx_sync & par_ok);
                end
            end
            default: state_next = S_IDLE;
        endcase
        // Leaving programming mode aborts any frame in flight, including a pending write.
        if (!prog_en) begin
            state_next = S_IDLE;
            byte_ok    = 1'b0;
            byte_bad   = 1'b0;
        end
    end

    always_comb begin
        word_next = word_buf;
        word_next[{byte_idx, 3'b000} +: 8] = shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef RH_BF_LOADER_PARITY_EN
            par_err    <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;

            if (state == S_IDLE || state_next != state || bit_done) cnt <= '0;
            else                                                   cnt <= cnt + CNT_W'(1);

            if (state == S_START) bit_idx <= '0;
            if (state == S_DATA && bit_done) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
`ifdef RH_BF_LOADER_PARITY_EN
            if (state == S_PARITY && bit_done) par_err <= rx_sync ^ (^shift);
`endif

            if (byte_ok) begin
                word_buf <= word_next;
                if (byte_idx == IDX_W'(NBYTES - 1)) begin
                    byte_idx <= '0;
                    if (!word_count[ADDR_W]) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= word_count[ADDR_W-1:0];
                        mem_wdata  <= word_next;
                        word_count <= word_count + (ADDR_W+1)'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end
            if (byte_bad) frame_err <= 1'b1;

            if (!prog_en) byte_idx <= '0;
            if (prog_rise) begin
                word_count <= '0;
                overflow   <= 1'b0;
                frame_err  <= 1'b0;
                byte_idx   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rh_bf_uart_loader.sv
// Scoreboard bench for rh_bf_uart_loader: random UART frames against a byte-queue reference model.
module tb_rh_bf_uart_loader;

    localparam int BC    = 16;
    localparam int AW    = 2;
    localparam int DW    = 16;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;
`ifdef RH_BF_LOADER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog_en = 1'b0;
    logic          uart_rx = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic [AW:0]   word_count;
    logic          overflow;
    logic          frame_err;

    rh_bf_uart_loader #(.BIT_CYCLES(BC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_en    (prog_en),
        .uart_rx    (uart_rx),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .word_count (word_count),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [7:0]    partial_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            exp_count = 0;
    bit            exp_ovf = 1'b0;
    bit            exp_ferr = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    logic          prev_we = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: accepted bytes queue up until a word is complete.
    task automatic model_frame(input logic [7:0] b, input bit good);
        logic [DW-1:0] w;
        if (!good) begin
            exp_ferr = 1'b1;
            return;
        end
        partial_q.push_back(b);
        if (partial_q.size() == NB) begin
            w = '0;
            for (int k = 0; k < NB; k++) w |= DW'(partial_q[k]) << (8 * k);
            if (exp_count < DEPTH) begin
                exp_q.push_back('{AW'(exp_count), w});
                last_addr = AW'(exp_count);
                last_data = w;
                exp_count++;
            end else begin
                exp_ovf = 1'b1;
            end
            partial_q.delete();
        end
    endtask

    task automatic set_prog(input logic v);
        @(negedge clk);
        if (v && !prog_en) begin
            exp_count = 0;
            exp_ovf   = 1'b0;
            exp_ferr  = 1'b0;
            partial_q.delete();
        end
        if (!v) partial_q.delete();
        prog_en = v;
        repeat (2) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        repeat (BC) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
        model_frame(b, stop && (!PAR || (par == ^b)));
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR) drive_bit(par);
        drive_bit(stop);
        uart_rx = 1'b1;
        if (!stop) repeat (BC) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b1, ^b);
    endtask

    task automatic check_status(input string tag);
        repeat (2 * BC) @(negedge clk);
        check({tag, "_word_count"}, word_count, exp_count);
        check({tag, "_overflow"}, overflow, exp_ovf);
        check({tag, "_frame_err"}, frame_err, exp_ferr);
        check({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    // Monitor: every write strobe is compared against the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && mem_we) begin
            check("we_one_cycle", prev_we, 1'b0);
            check("busy_during_we", busy, 1'b1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.addr);
                check("wr_data", mem_wdata, e.data);
            end
        end
        prev_we = mem_we;
    end

    initial begin
        int busy_cnt;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_word_count", word_count, '0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Little-endian assembly, then a partial word abandoned by dropping prog_en.
        set_prog(1'b1);
        send_good(8'h34);
        send_good(8'h12);
        send_good(8'h78);
        set_prog(1'b0);
        check_status("partial_drop");
        check("hold_addr", mem_addr, last_addr);
        check("hold_data", mem_wdata, last_data);

        // Framing error on the middle byte: it is dropped and does not advance the byte index.
        set_prog(1'b1);
        check("rise_clears_count", word_count, '0);
        send_good(8'hA5);
        send_frame(8'h5A, 1'b0, ^8'h5A);
        send_good(8'hC3);
        check_status("frame_err");

        // Random stream with back-to-back frames and occasional bad stop bits, driven into overflow.
        set_prog(1'b0);
        set_prog(1'b1);
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            send_frame(b, ($urandom_range(7) != 0), ^b);
            repeat ($urandom_range(BC / 2)) @(negedge clk);
        end
        for (int i = 0; i < 12 && !exp_ovf; i++) send_good(8'($urandom));
        check_status("random_overflow");
        check("hold_addr_full", mem_addr, last_addr);

        // A prog_en toggle clears the count and both sticky flags.
        set_prog(1'b0);
        set_prog(1'b1);
        check_status("toggle_clear");

        // Short low glitch: a false start, busy only for the half-bit START window.
        busy_cnt = 0;
        for (int i = 0; i < 2 * BC; i++) begin
            @(negedge clk);
            uart_rx = (i < BC / 4) ? 1'b0 : 1'b1;
            busy_cnt += int'(busy);
        end
        check("glitch_busy_cycles", busy_cnt, BC / 2);
        check_status("glitch");

        // prog_en dropped mid-frame: the frame and the held partial byte vanish.
        send_good(8'h11);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4 * BC) @(negedge clk);
        prog_en = 1'b0;
        partial_q.delete();
        repeat (6 * BC) @(negedge clk);
        uart_rx = 1'b1;
        check_status("abort");
        set_prog(1'b1);
        send_good(8'h22);
        send_good(8'h33);
        check_status("after_abort");

`ifdef RH_BF_LOADER_PARITY_EN
        set_prog(1'b0);
        set_prog(1'b1);
        send_frame(8'h03, 1'b1, 1'b1);
        check_status("parity_bad");
        set_prog(1'b0);
        set_prog(1'b1);
        send_frame(8'h03, 1'b1, 1'b0);
        send_frame(8'h04, 1'b1, 1'b1);
        check_status("parity_good");
`endif

        repeat (2 * BC) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
